// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller:
// fetch state encoding, instruction/PC widths and the buffered fetch entry.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int PC_W    = 64;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_HALTED = 2'd1,
    FS_FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [PC_W-1:0] pc,
                                              input logic [INSTR_W-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode valid/ready channel carrying the head instruction and its PC.
interface instr_fetch_ctrl_if #(
  parameter int XLEN = 64
);
  import fetch_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} fetch entries with synchronous flush.
// Head outputs read as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     push_entry,
  output logic [CNT_W-1:0] count,
  output logic             head_vld,
  output fetch_entry_t     head_entry
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_vld   = (count != '0);
  assign head_entry = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the PC, issues one word address per cycle to a synchronous
// instruction memory, buffers responses and hands them to decode. Macro: FETCH_ALIGN_CHECK_EN.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  instr_fetch_ctrl_if.master dec,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               fetch_fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [XLEN-1:0]  fetch_pc_p0;
  logic             inflight_vld_p1;
  logic [XLEN-1:0]  inflight_pc_p1;
  logic [CNT_W-1:0] count;
  logic             head_vld;
  fetch_entry_t     head_entry;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   credit_used;
  logic [XLEN-1:0]  target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc = redirect_pc;
`else
  assign target_pc = redirect_pc & ~XLEN'(2'b11);
`endif

  // A redirect kills both the same-cycle pop and the in-flight response.
  assign pop         = head_vld & dec.out_ready & ~redirect_valid;
  assign push        = inflight_vld_p1 & ~redirect_valid;
  assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight_vld_p1) - (CNT_W+1)'(pop);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      FS_RUN:    if (halt)  state_next = FS_HALTED;
      FS_HALTED: if (!halt) state_next = FS_RUN;
      default:   state_next = state;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect_valid && (|redirect_pc[1:0])) state_next = FS_FAULT;
`endif
    if (state == FS_RUN && !redirect_valid && credit_used < (CNT_W+1)'(BUF_DEPTH))
      issue = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FS_RUN;
    else       state <= state_next;
  end

  // Stage p0: address issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_p0     <= RESET_PC;
      inflight_vld_p1 <= 1'b0;
    end else begin
      if (redirect_valid)
        fetch_pc_p0 <= target_pc;
      else if (issue)
        fetch_pc_p0 <= fetch_pc_p0 + XLEN'(PC_STEP);
      inflight_vld_p1 <= issue;
    end
  end

  // Stage p1: memory response, captured into the FIFO with its PC
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= fetch_pc_p0;
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (make_entry(PC_W'(inflight_pc_p1), imem_rdata)),
    .count      (count),
    .head_vld   (head_vld),
    .head_entry (head_entry)
  );

  assign imem_addr     = fetch_pc_p0;
  assign dec.out_valid = head_vld;
  assign dec.out_instr = head_entry.instr;
  assign dec.out_pc    = head_entry.pc[XLEN-1:0];

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state == FS_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed timing checks plus randomized traffic against
// an in-order program-stream scoreboard. Honours FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  instr_fetch_ctrl_if #(.XLEN(64)) dec ();

  instr_fetch_ctrl #(
    .XLEN      (64),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec            (dec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00500093;
      64'h4:   return 32'h00A00113;
      64'h8:   return 32'h002081B3;
      64'hC:   return 32'h00000013;
      default: return ((a[31:0] ^ a[63:32]) * 32'h9E3779B1) + 32'h01234567;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Reference: decode must see the program stream in order from the last redirect target.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] gen_pc  = RESET_PC;
  bit          faulted = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      gen_pc  = RESET_PC;
      faulted = 1'b0;
    end else begin
      if (faulted) chk("fault_no_valid", dec.out_valid, 1'b0);
      if (dec.out_valid && dec.out_ready && !redirect_valid && !faulted) begin
        e = exp_q.pop_front();
        chk("sb_pc", dec.out_pc, e.pc);
        chk("sb_instr", dec.out_instr, e.instr);
        pops++;
      end
      if (redirect_valid && !faulted) begin
        exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) faulted = 1'b1;
        gen_pc = redirect_pc;
`else
        gen_pc = {redirect_pc[63:2], 2'b00};
`endif
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
        gen_pc = gen_pc + 64'd4;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    mid();
    chk("rst_mid_valid", dec.out_valid, 1'b0);
    chk("rst_mid_addr", imem_addr, RESET_PC);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      mid();
      if (dec.out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset          = 1'b1;
    dec.out_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    repeat (2) mid();
    chk("rst_valid", dec.out_valid, 1'b0);
    chk("rst_instr", dec.out_instr, 32'h0);
    chk("rst_pc", dec.out_pc, 64'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_fault", fetch_fault, 1'b0);

    // Basic stream from reset
    dec.out_ready = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    mid(); chk("t1_c0_valid", dec.out_valid, 1'b0); chk("t1_c0_addr", imem_addr, 64'h0);
    tick(); mid(); chk("t1_c1_valid", dec.out_valid, 1'b0); chk("t1_c1_addr", imem_addr, 64'h4);
    for (int i = 0; i < 4; i++) begin
      tick(); mid();
      chk("t1_valid", dec.out_valid, 1'b1);
      chk("t1_pc", dec.out_pc, 64'(4 * i));
      chk("t1_instr", dec.out_instr, mem_word(64'(4 * i)));
    end

    // Back-pressure from cycle 0
    dec.out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      mid();
      if (c == 2) chk("t2_addr_stop", imem_addr, 64'h8);
      if (c == 9) begin
        chk("t2_held_valid", dec.out_valid, 1'b1);
        chk("t2_held_pc", dec.out_pc, 64'h0);
        chk("t2_addr_held", imem_addr, 64'h8);
      end
      tick();
    end
    dec.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t2_resume_valid", dec.out_valid, 1'b1);
      chk("t2_resume_pc", dec.out_pc, 64'(4 * i));
      tick();
    end

    // Redirect in cycle 5 while the head is being popped
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mid(); tick();
    end
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    mid(); tick();
    redirect_valid = 1'b0;
    mid(); chk("t3_n1_addr", imem_addr, 64'h40); chk("t3_n1_valid", dec.out_valid, 1'b0);
    tick(); mid(); chk("t3_n2_valid", dec.out_valid, 1'b0);
    tick(); mid(); chk("t3_n3_valid", dec.out_valid, 1'b1); chk("t3_n3_pc", dec.out_pc, 64'h40);

    // Halt (cycle 9): one last issue at 0x4C, then the address freezes and the FIFO drains
    tick(); halt = 1'b1;
    mid(); tick(); mid(); tick();
    mid(); chk("t4_halt_addr_a", imem_addr, 64'h50);
    tick(); mid(); tick();
    mid(); chk("t4_halt_addr_b", imem_addr, 64'h50);
    tick(); mid(); chk("t4_drained", dec.out_valid, 1'b0);
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h100;
    mid(); tick();
    redirect_valid = 1'b0;
    mid(); chk("t4_redir_addr", imem_addr, 64'h100); chk("t4_redir_valid", dec.out_valid, 1'b0);
    repeat (3) begin tick(); mid(); end
    chk("t4_halted_addr", imem_addr, 64'h100); chk("t4_halted_valid", dec.out_valid, 1'b0);
    tick(); halt = 1'b0;
    wait_valid(10, ok);
    chk("t4_resume_seen", ok, 1'b1);
    chk("t4_resume_pc", dec.out_pc, 64'h100);
    tick();

    // Misaligned redirect
    do_reset();
    repeat (3) begin mid(); tick(); end
    redirect_valid = 1'b1; redirect_pc = 64'h42;
    mid(); tick();
    redirect_valid = 1'b0;
    mid();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t5_fault_n1", fetch_fault, 1'b1);
    chk("t5_valid_n1", dec.out_valid, 1'b0);
    repeat (3) begin tick(); mid(); end
    chk("t5_fault_hold", fetch_fault, 1'b1);
    chk("t5_valid_hold", dec.out_valid, 1'b0);
`else
    chk("t5_addr_aligned", imem_addr, 64'h40);
    chk("t5_fault_tied", fetch_fault, 1'b0);
    tick(); mid(); tick(); mid();
    chk("t5_valid", dec.out_valid, 1'b1);
    chk("t5_pc", dec.out_pc, 64'h40);
`endif
    tick();

    // PC wrap at the top of the address space
    do_reset();
    repeat (3) begin mid(); tick(); end
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    mid(); tick();
    redirect_valid = 1'b0;
    mid(); chk("t6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); mid(); chk("t6_addr_wrap", imem_addr, 64'h0);
    tick(); mid(); chk("t6_pc_top", dec.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); mid(); chk("t6_pc_wrap", dec.out_pc, 64'h0);
    chk("t6_instr_wrap", dec.out_instr, mem_word(64'h0));
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dec.out_ready  = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
      else
        redirect_pc = 64'($urandom_range(0, 1023));
`ifdef FETCH_ALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
      mid(); tick();
    end
    redirect_valid = 1'b0; halt = 1'b0; dec.out_ready = 1'b1;
    wait_valid(10, ok);
    chk("rand_drain_live", ok, 1'b1);
    chk("rand_activity", (pops > 500), 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
